serial_transfer_ctrl: RTL and testbench

Controller that sequences a serial word transfer between two shift registers. On a start request it parallel-loads a source word into register RB, then asserts shift_control for exactly WIDTH clocks so RB's serial output feeds the destination register RA's serial input, LSB first. It wraps the existing shift-register datapath and adds the start/busy/done handshake and bit counter that the bare register lacks.

---
 rtl/serial_pkg.sv | 14 +
 rtl/shift_register.sv | 35 +++
 rtl/serial_transfer_ctrl.sv | 115 +++++++++++
 tb/tb_serial_transfer_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transfer controller.
//   state_e      : controller FSM state encoding
//   DefaultWidth : register width used when the top is not overridden
package serial_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_register.sv
// Right-shifting register with parallel load and serial in/out.
//   clk           : rising-edge clock
//   clear         : asynchronous active-low reset, forces Q to 0
//   SI            : serial input, enters at the MSB
//   shift_control : shift enable (one position toward the LSB per edge)
//   load          : parallel load enable, has priority over shifting
//   d             : parallel load data
//   Q             : register contents
//   SO            : serial output (current LSB)
module shift_register #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             SI,
    input  logic             shift_control,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             SO
);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            Q <= '0;
        end else if (load) begin
            Q <= d;
        end else if (shift_control) begin
            Q <= {SI, Q[WIDTH-1:1]};
        end
    end

    assign SO = Q[0];

endmodule

// File: rtl/serial_transfer_ctrl.sv
// Sequences a WIDTH-bit serial transfer from RB into RA, LSB first.
//   clk           : rising-edge clock
//   clear         : asynchronous active-low reset, aborts any transfer
//   start         : transfer request, only honoured in IDLE
//   load_data     : source word, captured into RB on the accepting edge
//   rotate        : 1 recirculates RB's SO into its MSB, 0 shifts in zeros
//   shift_control : high for exactly WIDTH cycles while shifting
//   RA, RB        : destination / source register contents
//   busy          : high while shifting and during the done cycle
//   done          : one-cycle completion pulse
module serial_transfer_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] load_data,
    input  logic             rotate,
    output logic             shift_control,
    output logic [WIDTH-1:0] RA,
    output logic [WIDTH-1:0] RB,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            accept;
    logic            rb_si;
    logic            rb_so;
    logic            ra_so;

    // RB captures the source word on the same edge the FSM leaves IDLE.
    assign accept = (state_q == StIdle) && start;
    assign rb_si  = rotate ? rb_so : 1'b0;

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            shift_control <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q       <= StShift;
                        cnt_q         <= '0;
                        shift_control <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q == CntLast) begin
                        state_q       <= StDone;
                        cnt_q         <= '0;
                        shift_control <= 1'b0;
                        done          <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_q       <= StIdle;
                    cnt_q         <= '0;
                    shift_control <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                end
            endcase
        end
    end

    shift_register #(
        .WIDTH(WIDTH)
    ) u_rb (
        .clk          (clk),
        .clear        (clear),
        .SI           (rb_si),
        .shift_control(shift_control),
        .load         (accept),
        .d            (load_data),
        .Q            (RB),
        .SO           (rb_so)
    );

    shift_register #(
        .WIDTH(WIDTH)
    ) u_ra (
        .clk          (clk),
        .clear        (clear),
        .SI           (rb_so),
        .shift_control(shift_control),
        .load         (1'b0),
        .d            ({WIDTH{1'b0}}),
        .Q            (RA),
        .SO           (ra_so)
    );

    logic unused_ra_so;
    assign unused_ra_so = ra_so;

endmodule

// File: tb/tb_serial_transfer_ctrl.sv
module tb_serial_transfer_ctrl;

    logic       clk;
    logic       clear;
    logic       start;
    logic [3:0] load_data;
    logic       rotate;
    logic       sc;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       busy;
    logic       done;

    logic       start8;
    logic [7:0] load_data8;
    logic       rotate8;
    logic       sc8;
    logic [7:0] ra8;
    logic [7:0] rb8;
    logic       busy8;
    logic       done8;

    int n_checks = 0;
    int n_pass   = 0;

    serial_transfer_ctrl #(
        .WIDTH(4)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .start        (start),
        .load_data    (load_data),
        .rotate       (rotate),
        .shift_control(sc),
        .RA           (ra),
        .RB           (rb),
        .busy         (busy),
        .done         (done)
    );

    serial_transfer_ctrl #(
        .WIDTH(8)
    ) dut8 (
        .clk          (clk),
        .clear        (clear),
        .start        (start8),
        .load_data    (load_data8),
        .rotate       (rotate8),
        .shift_control(sc8),
        .RA           (ra8),
        .RB           (rb8),
        .busy         (busy8),
        .done         (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, ending 1 time unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected values for the 1011 / rotate=0 transfer, one entry per shift edge.
    logic [3:0] exp_ra [4] = '{4'b1000, 4'b1100, 4'b0110, 4'b1011};
    logic [3:0] exp_rb [4] = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};

    int n_sc;
    int n_done;
    int done_at;

    initial begin
        clear      = 1'b0;
        start      = 1'b0;
        load_data  = 4'b0000;
        rotate     = 1'b0;
        start8     = 1'b0;
        load_data8 = 8'h00;
        rotate8    = 1'b0;

        // Reset asserted before any clock edge.
        #2;
        check("rst_ra", {28'b0, ra}, 32'h0);
        check("rst_rb", {28'b0, rb}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_sc", {31'b0, sc}, 32'h0);
        step(1);
        clear = 1'b1;

        // Transfer 1011 with zero fill.
        load_data = 4'b1011;
        rotate    = 1'b0;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
        load_data = 4'b0000;
        check("t1_accept_rb", {28'b0, rb}, 32'hb);
        check("t1_accept_ra", {28'b0, ra}, 32'h0);
        check("t1_accept_busy", {31'b0, busy}, 32'h1);
        n_sc   = sc ? 1 : 0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("t1_ra_%0d", i), {28'b0, ra}, {28'b0, exp_ra[i]});
            check($sformatf("t1_rb_%0d", i), {28'b0, rb}, {28'b0, exp_rb[i]});
            if (sc) n_sc++;
            if (done) n_done++;
        end
        check("t1_done_edge4", {31'b0, done}, 32'h1);
        check("t1_busy_done", {31'b0, busy}, 32'h1);
        step(1);
        if (done) n_done++;
        check("t1_sc_cycles", n_sc, 4);
        check("t1_done_pulses", n_done, 1);
        check("t1_idle_busy", {31'b0, busy}, 32'h0);
        check("t1_idle_ra", {28'b0, ra}, 32'hb);

        // Transfer 0110 with rotate: RB preserved.
        load_data = 4'b0110;
        rotate    = 1'b1;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("t2_rb_edge1", {28'b0, rb}, 32'h3);
        step(3);
        check("t2_ra", {28'b0, ra}, 32'h6);
        check("t2_rb", {28'b0, rb}, 32'h6);
        check("t2_done", {31'b0, done}, 32'h1);
        step(1);
        rotate = 1'b0;

        // Start held high: back-to-back transfers every 6 cycles.
        load_data = 4'b0011;
        start     = 1'b1;
        step(1);
        step(1);
        load_data = 4'b1110;
        step(3);
        check("t3_ra_w0", {28'b0, ra}, 32'h3);
        check("t3_done_w0", {31'b0, done}, 32'h1);
        step(1);
        check("t3_gap_busy", {31'b0, busy}, 32'h0);
        step(1);
        check("t3_reaccept_busy", {31'b0, busy}, 32'h1);
        check("t3_reaccept_sc", {31'b0, sc}, 32'h1);
        check("t3_reaccept_rb", {28'b0, rb}, 32'he);
        load_data = 4'b0101;
        step(4);
        check("t3_ra_w1", {28'b0, ra}, 32'he);
        check("t3_done_w1", {31'b0, done}, 32'h1);
        start = 1'b0;
        step(2);
        check("t3_stays_idle", {31'b0, busy}, 32'h0);

        // Abort mid-transfer with an asynchronous clear.
        load_data = 4'b1011;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        #2;
        clear = 1'b0;
        #1;
        check("ab_ra", {28'b0, ra}, 32'h0);
        check("ab_rb", {28'b0, rb}, 32'h0);
        check("ab_busy", {31'b0, busy}, 32'h0);
        check("ab_sc", {31'b0, sc}, 32'h0);
        check("ab_done", {31'b0, done}, 32'h0);
        #1;
        clear     = 1'b1;
        load_data = 4'b1001;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        check("ab_restart_busy", {31'b0, busy}, 32'h1);
        step(4);
        check("ab_restart_ra", {28'b0, ra}, 32'h9);
        check("ab_restart_done", {31'b0, done}, 32'h1);
        step(1);

        // WIDTH=8 instance.
        load_data8 = 8'ha5;
        rotate8    = 1'b0;
        start8     = 1'b1;
        step(1);
        start8     = 1'b0;
        load_data8 = 8'h00;
        n_sc    = 0;
        done_at = -1;
        for (int j = 0; j < 10; j++) begin
            if (sc8) n_sc++;
            if (done8 && done_at < 0) done_at = j;
            if (j == 8) check("w8_ra", {24'b0, ra8}, 32'ha5);
            if (j < 9) step(1);
        end
        check("w8_sc_cycles", n_sc, 8);
        check("w8_done_at", done_at, 8);
        check("w8_idle", {31'b0, busy8}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
